zeroriscy_vrf_masked: RTL and testbench
=======================================

# zeroriscy_vrf_masked

Parametrised vector register file for the zeroriscy vector extension: NUM_VREGS registers of NUM_LANES elements, each ELEM_W bits wide. It has two combinational read ports with same-cycle write bypass and one write port with per-lane masking and a scalar-broadcast mode. A built-in clear sequencer zeroes the whole file, one register per cycle, under a ready/busy handshake. It sits between the vector decoder/issue stage (reads) and the vector ALU/LSU writeback.

## Interface
- NUM_VREGS, 16, number of vector registers (power of two, >=2)
- NUM_LANES, 4, elements per register
- ELEM_W, 32, element width in bits
- ADDR_W, $clog2(NUM_VREGS), register address width (derived, not overridden)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- raddr_a_i  in  ADDR_W  read port A address
- rdata_a_o  out  NUM_LANES x ELEM_W  read port A data, lane i at [i]
- raddr_b_i  in  ADDR_W  read port B address
- rdata_b_o  out  NUM_LANES x ELEM_W  read port B data
- we_i  in  1  write request
- wready_o  out  1  write port can accept; write occurs only when we_i & wready_o
- waddr_i  in  ADDR_W  write address
- wdata_i  in  NUM_LANES x ELEM_W  write data
- wmask_i  in  NUM_LANES  per-lane write enable; lane i is written only if wmask_i[i]
- wbcast_i  in  1  1: wdata_i[0] is written to every enabled lane; 0: lane i receives wdata_i[i]
- clr_req_i  in  1  request to zero the whole file
- clr_busy_o  out  1  clear sequence in progress
- clr_done_o  out  1  one-cycle pulse when the clear completes

## Operation
- Storage: NUM_VREGS x NUM_LANES x ELEM_W flops. All bits are reset to 0 asynchronously.
- Effective write lane data: wbcast_i ? wdata_i[0] : wdata_i[i]. Lanes with wmask_i[i]=0 keep their old value. A write with wmask_i=0 is legal and has no effect.
- FSM states: IDLE, CLEAR, DONE. Reset state is IDLE.
- IDLE:
  - wready_o=1.
  - If clr_req_i=1, go to CLEAR with clr_cnt=0.
  - An external write in the same cycle as clr_req_i is still performed; the clear then overwrites it.
- CLEAR:
  - wready_o=0; external writes are dropped.
  - Each cycle, every lane of reg[clr_cnt] is written to 0.
  - clr_cnt increments modulo NUM_VREGS.
  - When clr_cnt=NUM_VREGS-1, go to DONE.
  - clr_req_i is ignored in this state.
- DONE:
  - clr_done_o=1 and wready_o=1; the file is fully zero.
  - Go to IDLE unconditionally.
  - An external write in DONE is accepted.
  - clr_req_i is ignored in DONE and is sampled again in IDLE.
- clr_busy_o = (state==CLEAR).
- Read ports are purely combinational. For each lane: if a write to raddr hits this cycle with that lane enabled, return the write data (bypass). Otherwise return the stored value.
- The bypass applies to both external writes and clear-sequencer writes. During CLEAR, a read of reg[clr_cnt] returns 0 on all lanes.
- Port A and port B may use the same address, and either may equal waddr_i. All combinations are legal.

## Timing
- Reset values: rdata_*_o = 0 for any address, wready_o=1, clr_busy_o=0, clr_done_o=0.
- Write latency: 0 cycles to the read ports (bypass); the value is stored at the next posedge.
- Clear duration:
  - clr_req_i is sampled high at edge T.
  - clr_busy_o is high for cycles T+1 .. T+NUM_VREGS.
  - clr_done_o is high in cycle T+NUM_VREGS+1.
  - wready_o is low for exactly NUM_VREGS cycles.
- Reset asserted mid-clear: immediately go to IDLE, zero the file and clr_cnt, and drop clr_busy_o. No clr_done_o pulse is produced.
- clr_cnt is ADDR_W bits wide. It wraps to 0 on the DONE transition, so no overflow is possible.

## Structure
- Package zeroriscy_vrf_pkg holds:
  - vrf_state_e {IDLE, CLEAR, DONE};
  - default parameter constants;
  - a helper function that computes masked/broadcast lane data.
- Sub-module zeroriscy_vrf_read_port (address, storage view, write-bypass inputs -> lane data), instantiated twice (A, B).
- The top module holds the storage, write-lane logic, FSM and clr_cnt.

## Test plan
- Reset, then read all 16 addresses on A and B -> every lane 0; wready_o=1, clr_busy_o=0.
- Write v3, wmask=4'b0101, wbcast=0, wdata={D,C,B,A} -> same-cycle raddr_a=3 reads {0,C,0,A}; next cycle the stored value is {0,C,0,A}.
- Write v5, wbcast=1, wmask=4'b1111, wdata[0]=32'hDEADBEEF -> all four lanes of v5 read 32'hDEADBEEF, on both A and B.
- After filling all registers with 32'hFFFFFFFF, pulse clr_req_i:
  - busy for 16 cycles, then clr_done_o for 1 cycle;
  - we_i during busy is dropped (e.g. v7 stays 0 afterwards);
  - the register under clear reads 0 via bypass.
- Drive clr_req_i and a write to v2=32'h1 in the same IDLE cycle -> the write is accepted, and v2 reads 0 after clr_done_o.
- Assert rst_n=0 at cycle 5 of a clear -> clr_busy_o=0 at once, no clr_done_o, the file is all zero, and a new clear is accepted after reset release.

Source files
------------

// File: rtl/zeroriscy_vrf_pkg.sv
// Shared types and defaults for the zeroriscy vector register file.
package zeroriscy_vrf_pkg;

   localparam int VRF_NUM_VREGS = 16;
   localparam int VRF_NUM_LANES = 4;
   localparam int VRF_ELEM_W    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } vrf_state_e;

   // Source lane for write data: broadcast takes everything from lane 0.
   function automatic int wr_src_lane(input logic bcast, input int lane);
      return bcast ? 0 : lane;
   endfunction

endpackage

// File: rtl/zeroriscy_vrf_read_port.sv
// One combinational read port with per-lane write bypass.
module zeroriscy_vrf_read_port
   import zeroriscy_vrf_pkg::*;
#(
   parameter  int NUM_VREGS = VRF_NUM_VREGS,
   parameter  int NUM_LANES = VRF_NUM_LANES,
   parameter  int ELEM_W    = VRF_ELEM_W,
   localparam int ADDR_W    = $clog2(NUM_VREGS)
) (
   input  logic [ADDR_W-1:0]                 raddr,
   input  logic [NUM_LANES-1:0][ELEM_W-1:0]  regs [NUM_VREGS],
   input  logic                              wr_en,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [NUM_LANES-1:0]              wr_lane_we,
   input  logic [NUM_LANES-1:0][ELEM_W-1:0]  wr_data,
   output logic [NUM_LANES-1:0][ELEM_W-1:0]  rdata
);

   // Per lane: forward the in-flight write when it targets this address, else stored data.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         rdata[i] = (wr_en && (wr_addr == raddr) && wr_lane_we[i]) ? wr_data[i]
                                                                    : regs[raddr][i];
      end
   end

endmodule

// File: rtl/zeroriscy_vrf_masked.sv
// Vector register file: two bypassed read ports, one masked/broadcast write
// port, and a one-register-per-cycle clear sequencer.
module zeroriscy_vrf_masked
   import zeroriscy_vrf_pkg::*;
#(
   parameter  int NUM_VREGS = VRF_NUM_VREGS,
   parameter  int NUM_LANES = VRF_NUM_LANES,
   parameter  int ELEM_W    = VRF_ELEM_W,
   localparam int ADDR_W    = $clog2(NUM_VREGS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [ADDR_W-1:0]                 raddr_a_i,
   output logic [NUM_LANES-1:0][ELEM_W-1:0]  rdata_a_o,
   input  logic [ADDR_W-1:0]                 raddr_b_i,
   output logic [NUM_LANES-1:0][ELEM_W-1:0]  rdata_b_o,
   input  logic                              we_i,
   output logic                              wready_o,
   input  logic [ADDR_W-1:0]                 waddr_i,
   input  logic [NUM_LANES-1:0][ELEM_W-1:0]  wdata_i,
   input  logic [NUM_LANES-1:0]              wmask_i,
   input  logic                              wbcast_i,
   input  logic                              clr_req_i,
   output logic                              clr_busy_o,
   output logic                              clr_done_o
);

   logic [NUM_LANES-1:0][ELEM_W-1:0] mem [NUM_VREGS];

   vrf_state_e  state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q;

   // Merged write request: the clear sequencer or the external port.
   logic                             wr_en;
   logic [ADDR_W-1:0]                wr_addr;
   logic [NUM_LANES-1:0]             wr_lane_we;
   logic [NUM_LANES-1:0][ELEM_W-1:0] wr_data;

   // Select the write source; the clear has priority (external port is not ready then).
   always_comb begin
      // NOTE: every output gets a default up front so no path leaves it unassigned (no latch).
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_lane_we = '0;
      wr_data    = '0;
      if (state_q == CLEAR) begin
         wr_en      = 1'b1;
         wr_addr    = clr_cnt_q;
         wr_lane_we = '1;
      end else if (we_i && wready_o) begin
         wr_en      = 1'b1;
         wr_addr    = waddr_i;
         wr_lane_we = wmask_i;
         for (int i = 0; i < NUM_LANES; i++) begin
            wr_data[i] = wdata_i[wr_src_lane(wbcast_i, i)];
         end
      end
   end

   // Storage update, lane-granular.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the whole array is reset because reads must return 0 right after reset;
         // this forces flops rather than a RAM macro.
         for (int v = 0; v < NUM_VREGS; v++) begin
            mem[v] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_lane_we[i]) begin
               mem[wr_addr][i] <= wr_data[i];
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clr_req_i) state_d = CLEAR;
         CLEAR:   if (clr_cnt_q == ADDR_W'(NUM_VREGS - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      wready_o   = (state_q != CLEAR);
      clr_busy_o = (state_q == CLEAR);
      clr_done_o = (state_q == DONE);
   end

   // Clear counter: held at 0 outside CLEAR, wraps to 0 on the last register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  clr_cnt_q <= '0;
      else if (state_q == CLEAR)   clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      else                         clr_cnt_q <= '0;
   end

   zeroriscy_vrf_read_port #(
      .NUM_VREGS (NUM_VREGS),
      .NUM_LANES (NUM_LANES),
      .ELEM_W    (ELEM_W)
   ) u_read_a (
      .raddr      (raddr_a_i),
      .regs       (mem),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_lane_we (wr_lane_we),
      .wr_data    (wr_data),
      .rdata      (rdata_a_o)
   );

   zeroriscy_vrf_read_port #(
      .NUM_VREGS (NUM_VREGS),
      .NUM_LANES (NUM_LANES),
      .ELEM_W    (ELEM_W)
   ) u_read_b (
      .raddr      (raddr_b_i),
      .regs       (mem),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_lane_we (wr_lane_we),
      .wr_data    (wr_data),
      .rdata      (rdata_b_o)
   );

endmodule

// File: tb/tb_zeroriscy_vrf_masked.sv
// Self-checking bench for zeroriscy_vrf_masked: directed scenarios then random traffic,
// compared against a register-array model of the file and the clear timing.
module tb_zeroriscy_vrf_masked;

   localparam int NV = 16;
   localparam int NL = 4;
   localparam int EW = 32;

   logic                   clk;
   logic                   rst_n;
   logic [3:0]             raddr_a_i, raddr_b_i, waddr_i;
   logic [NL-1:0][EW-1:0]  rdata_a_o, rdata_b_o, wdata_i;
   logic                   we_i, wready_o, wbcast_i, clr_req_i, clr_busy_o, clr_done_o;
   logic [NL-1:0]          wmask_i;

   zeroriscy_vrf_masked dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raddr_a_i  (raddr_a_i),
      .rdata_a_o  (rdata_a_o),
      .raddr_b_i  (raddr_b_i),
      .rdata_b_o  (rdata_b_o),
      .we_i       (we_i),
      .wready_o   (wready_o),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .wmask_i    (wmask_i),
      .wbcast_i   (wbcast_i),
      .clr_req_i  (clr_req_i),
      .clr_busy_o (clr_busy_o),
      .clr_done_o (clr_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: register contents, plus how many clear cycles remain and whether
   // the done cycle is current.
   logic [EW-1:0] mem_m [NV][NL];
   logic [EW-1:0] nxt   [NV][NL];
   int            clr_left = 0;
   bit            in_done  = 1'b0;

   int busy_cnt, nready_cnt, done_cnt;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Contents of a register as seen after this cycle's write (equals the bypass view).
   function automatic logic [127:0] rd(input int a);
      logic [127:0] r;
      for (int l = 0; l < NL; l++) r[l*EW +: EW] = nxt[a][l];
      return r;
   endfunction

   task automatic model_zero();
      for (int v = 0; v < NV; v++)
         for (int l = 0; l < NL; l++) mem_m[v][l] = '0;
      clr_left = 0;
      in_done  = 1'b0;
   endtask

   // One clock cycle: drive after negedge, check outputs, advance the model.
   task automatic cycle(input logic we, input int wa, input logic [127:0] wd,
                        input logic [3:0] wm, input logic bc, input logic cr,
                        input int ra, input int rb);
      @(negedge clk);
      we_i      = we;
      waddr_i   = wa[3:0];
      wdata_i   = wd;
      wmask_i   = wm;
      wbcast_i  = bc;
      clr_req_i = cr;
      raddr_a_i = ra[3:0];
      raddr_b_i = rb[3:0];
      nxt = mem_m;
      if (clr_left > 0) begin
         for (int l = 0; l < NL; l++) nxt[NV - clr_left][l] = '0;
      end else if (we) begin
         for (int l = 0; l < NL; l++)
            if (wm[l]) nxt[wa][l] = bc ? wd[EW-1:0] : wd[l*EW +: EW];
      end
      #1;
      check("rdata_a", rdata_a_o, rd(ra));
      check("rdata_b", rdata_b_o, rd(rb));
      check("wready",  {127'd0, wready_o},   {127'd0, (clr_left == 0)});
      check("busy",    {127'd0, clr_busy_o}, {127'd0, (clr_left > 0)});
      check("done",    {127'd0, clr_done_o}, {127'd0, in_done});
      mem_m = nxt;
      if (clr_left > 0) begin
         clr_left--;
         if (clr_left == 0) in_done = 1'b1;
      end else if (in_done) begin
         in_done = 1'b0;
      end else if (cr) begin
         clr_left = NV;
      end
   endtask

   task automatic idle(input int ra, input int rb);
      cycle(1'b0, 0, '0, 4'h0, 1'b0, 1'b0, ra, rb);
   endtask

   task automatic fill_all(input logic [31:0] val);
      for (int i = 0; i < NV; i++) cycle(1'b1, i, {4{val}}, 4'hF, 1'b0, 1'b0, i, i);
   endtask

   initial begin
      logic [127:0] wd;
      rst_n = 1'b0;
      we_i = 1'b0; waddr_i = '0; wdata_i = '0; wmask_i = '0; wbcast_i = 1'b0;
      clr_req_i = 1'b0; raddr_a_i = '0; raddr_b_i = '0;
      model_zero();
      nxt = mem_m;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state on every address.
      for (int i = 0; i < NV; i++) idle(i, NV - 1 - i);

      // Masked write, no broadcast.
      cycle(1'b1, 3, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001},
            4'b0101, 1'b0, 1'b0, 3, 0);
      check("v3_bypass", rdata_a_o, {32'h0, 32'hCCCC0003, 32'h0, 32'hAAAA0001});
      idle(3, 3);
      check("v3_stored", rdata_a_o, {32'h0, 32'hCCCC0003, 32'h0, 32'hAAAA0001});

      // Broadcast write, upper lanes of wdata must be ignored.
      cycle(1'b1, 5, {32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF},
            4'hF, 1'b1, 1'b0, 5, 5);
      check("v5_bcast_a", rdata_a_o, {4{32'hDEADBEEF}});
      check("v5_bcast_b", rdata_b_o, {4{32'hDEADBEEF}});

      // Full clear with writes to v7 attempted while busy.
      fill_all(32'hFFFFFFFF);
      cycle(1'b0, 0, '0, 4'h0, 1'b0, 1'b1, 0, 7);
      busy_cnt = 0; nready_cnt = 0; done_cnt = 0;
      for (int k = 0; k < NV + 2; k++) begin
         cycle(clr_left > 0, 7, {4{32'h12345678}}, 4'hF, 1'b0, 1'b0,
               (clr_left > 0) ? NV - clr_left : 7, 7);
         busy_cnt   += int'(clr_busy_o);
         nready_cnt += int'(!wready_o);
         done_cnt   += int'(clr_done_o);
      end
      check("busy_cycles",   busy_cnt,   NV);
      check("nready_cycles", nready_cnt, NV);
      check("done_pulses",   done_cnt,   1);
      idle(7, 0);
      check("v7_dropped", rdata_a_o, '0);

      // Write in the same cycle as the clear request: accepted, then cleared.
      cycle(1'b1, 2, {4{32'h1}}, 4'h1, 1'b0, 1'b1, 2, 2);
      check("v2_same_cycle", rdata_a_o, {96'h0, 32'h1});
      done_cnt = 0;
      for (int k = 0; k < NV + 1; k++) begin
         idle(2, 0);
         done_cnt += int'(clr_done_o);
      end
      check("v2_clear_done", done_cnt, 1);
      idle(2, 2);
      check("v2_cleared", rdata_a_o, '0);

      // Reset in the middle of a clear.
      fill_all(32'hFFFFFFFF);
      cycle(1'b0, 0, '0, 4'h0, 1'b0, 1'b1, 0, 0);
      for (int k = 0; k < 4; k++) idle(9, 15);
      @(negedge clk);
      we_i = 1'b0; clr_req_i = 1'b0; raddr_a_i = 4'd9; raddr_b_i = 4'd15;
      rst_n = 1'b0;
      model_zero();
      nxt = mem_m;
      #1;
      check("rst_busy",   {127'd0, clr_busy_o}, '0);
      check("rst_done",   {127'd0, clr_done_o}, '0);
      check("rst_wready", {127'd0, wready_o},   128'd1);
      check("rst_v9",     rdata_a_o, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) idle(i, NV - 1 - i);
      cycle(1'b0, 0, '0, 4'h0, 1'b0, 1'b1, 0, 0);
      done_cnt = 0;
      for (int k = 0; k < NV + 1; k++) begin
         idle(k % NV, 0);
         done_cnt += int'(clr_done_o);
      end
      check("reclear_done", done_cnt, 1);

      // Random traffic with occasional clear requests.
      for (int k = 0; k < 400; k++) begin
         wd = {$urandom, $urandom, $urandom, $urandom};
         cycle(1'($urandom), int'($urandom_range(0, NV - 1)), wd, 4'($urandom),
               1'($urandom), ($urandom_range(0, 29) == 0),
               int'($urandom_range(0, NV - 1)), int'($urandom_range(0, NV - 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
